// File: rtl/prescaled_updown_counter_if.sv
// Bus bundle for prescaled_updown_counter: count controls in, count and flags out.
// The master drives the controls; the slave (the counter) drives count and flags.
interface prescaled_updown_counter_if #(
  parameter int WIDTH = 8
);
  logic             do_count;
  logic             increment;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             at_max;
  logic             at_min;

  modport master (
    output do_count, increment, load, load_value,
    input  count, tc, at_max, at_min
  );

  modport slave (
    input  do_count, increment, load, load_value,
    output count, tc, at_max, at_min
  );
endinterface

// File: rtl/prescaled_updown_counter.sv
// Up/down counter with modulus, wrap/saturate mode, clock-enable prescaler and clamped load.
// Defining PRESCALED_COUNTER_INPUT_SYNC_EN adds 2-flop synchronizers on do_count, increment and load.
module prescaled_updown_counter #(
  parameter int              WIDTH     = 8,
  parameter longint unsigned MAX_VALUE = 255,
  parameter int              PRESCALE  = 1,
  parameter bit              SATURATE  = 1'b0
) (
  input logic                      clk,
  input logic                      rst,
  prescaled_updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_COUNT     = WIDTH'(MAX_VALUE);
  localparam logic [15:0]      PRESCALE_LAST = 16'(PRESCALE - 1);

  logic do_count_i;
  logic increment_i;
  logic load_i;

`ifdef PRESCALED_COUNTER_INPUT_SYNC_EN
  // Two flop stages per control input; load_value is expected to be held stable instead.
  logic [2:0] sync_meta;
  logic [2:0] sync_out;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      sync_meta <= {bus.do_count, bus.increment, bus.load};
      sync_out  <= sync_meta;
    end
  end

  assign {do_count_i, increment_i, load_i} = sync_out;
`else
  assign do_count_i  = bus.do_count;
  assign increment_i = bus.increment;
  assign load_i      = bus.load;
`endif

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [15:0]      prescale_q;
  logic [15:0]      prescale_d;
  logic             tc_q;
  logic             tc_d;
  logic             step;

  always_comb begin
    count_d    = count_q;
    prescale_d = prescale_q;
    tc_d       = 1'b0;
    step       = 1'b0;

    if (load_i) begin
      count_d    = (bus.load_value > MAX_COUNT) ? MAX_COUNT : bus.load_value;
      prescale_d = '0;
    end else if (do_count_i) begin
      if (prescale_q == PRESCALE_LAST) begin
        prescale_d = '0;
        step       = 1'b1;
      end else begin
        prescale_d = prescale_q + 16'd1;
      end
    end

    // A step past either boundary always pulses tc; only wrap mode moves the count.
    if (step) begin
      if (increment_i) begin
        if (count_q < MAX_COUNT) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          tc_d = 1'b1;
          if (!SATURATE) count_d = '0;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          tc_d = 1'b1;
          if (!SATURATE) count_d = MAX_COUNT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q    <= '0;
      prescale_q <= '0;
      tc_q       <= 1'b0;
    end else begin
      count_q    <= count_d;
      prescale_q <= prescale_d;
      tc_q       <= tc_d;
    end
  end

  assign bus.count  = count_q;
  assign bus.tc     = tc_q;
  assign bus.at_max = (count_q == MAX_COUNT);
  assign bus.at_min = (count_q == '0);

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Bench for prescaled_updown_counter: three instances (wrap, saturate, prescale-by-4) share
// one stimulus stream and are compared against an arithmetic model of the counting rules.
module tb_prescaled_updown_counter;

  localparam int W         = 8;
  localparam int MODEL_MAX = 9;

  logic         clk;
  logic         rst;
  logic         do_count;
  logic         increment;
  logic         load;
  logic [W-1:0] load_value;

  int checks = 0;
  int errors = 0;

  prescaled_updown_counter_if #(.WIDTH(W)) if_w ();
  prescaled_updown_counter_if #(.WIDTH(W)) if_s ();
  prescaled_updown_counter_if #(.WIDTH(W)) if_p ();

  assign if_w.do_count = do_count;  assign if_w.increment = increment;
  assign if_w.load     = load;      assign if_w.load_value = load_value;
  assign if_s.do_count = do_count;  assign if_s.increment = increment;
  assign if_s.load     = load;      assign if_s.load_value = load_value;
  assign if_p.do_count = do_count;  assign if_p.increment = increment;
  assign if_p.load     = load;      assign if_p.load_value = load_value;

  prescaled_updown_counter #(.WIDTH(W), .MAX_VALUE(9), .PRESCALE(1), .SATURATE(1'b0))
    dut_wrap (.clk(clk), .rst(rst), .bus(if_w));
  prescaled_updown_counter #(.WIDTH(W), .MAX_VALUE(9), .PRESCALE(1), .SATURATE(1'b1))
    dut_sat (.clk(clk), .rst(rst), .bus(if_s));
  prescaled_updown_counter #(.WIDTH(W), .MAX_VALUE(9), .PRESCALE(4), .SATURATE(1'b0))
    dut_pre (.clk(clk), .rst(rst), .bus(if_p));

  logic [W-1:0] d_count [3];
  logic         d_tc    [3];
  logic         d_max   [3];
  logic         d_min   [3];

  assign d_count[0] = if_w.count;  assign d_tc[0] = if_w.tc;
  assign d_max[0]   = if_w.at_max; assign d_min[0] = if_w.at_min;
  assign d_count[1] = if_s.count;  assign d_tc[1] = if_s.tc;
  assign d_max[1]   = if_s.at_max; assign d_min[1] = if_s.at_min;
  assign d_count[2] = if_p.count;  assign d_tc[2] = if_p.tc;
  assign d_max[2]   = if_p.at_max; assign d_min[2] = if_p.at_min;

  // Model state: count value, enabled cycles since the last step, and the tc pulse.
  int m_count [3];
  int m_en    [3];
  bit m_tc    [3];
  int m_pre   [3] = '{1, 1, 4};
  bit m_sat   [3] = '{1'b0, 1'b1, 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_update();
    int nxt;
    for (int k = 0; k < 3; k++) begin
      m_tc[k] = 1'b0;
      if (!rst) begin
        m_count[k] = 0;
        m_en[k]    = 0;
      end else if (load) begin
        m_count[k] = (int'(load_value) > MODEL_MAX) ? MODEL_MAX : int'(load_value);
        m_en[k]    = 0;
      end else if (do_count) begin
        m_en[k]++;
        if (m_en[k] == m_pre[k]) begin
          m_en[k] = 0;
          nxt = increment ? m_count[k] + 1 : m_count[k] - 1;
          if (nxt > MODEL_MAX || nxt < 0) begin
            m_tc[k] = 1'b1;
            if (!m_sat[k]) m_count[k] = (nxt < 0) ? MODEL_MAX : 0;
          end else begin
            m_count[k] = nxt;
          end
        end
      end
    end
  endtask

  // One rising edge with the current inputs; outputs are then sampled at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; do_count = 1'b0; increment = 1'b0; load = 1'b0; load_value = '0;
    cycle();
    cycle();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_count[k] !== 8'd0 || d_tc[k] !== 1'b0 || d_min[k] !== 1'b1 || d_max[k] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset dut%0d: got count=%0d tc=%b min=%b max=%b, want 0 0 1 0",
                 k, d_count[k], d_tc[k], d_min[k], d_max[k]);
      end
    end
  endtask

  task automatic test_wrap_up();
    rst = 1'b1; do_count = 1'b1; increment = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      checks++;
      if (d_count[0] !== 8'(i % 10) || d_tc[0] !== (i == 10) || d_max[0] !== (i == 9)) begin
        errors++;
        $display("[TB] FAIL wrap_up step %0d: got count=%0d tc=%b max=%b, want %0d %b %b",
                 i, d_count[0], d_tc[0], d_max[0], i % 10, i == 10, i == 9);
      end
      checks++;
      if (d_count[1] !== 8'((i < 10) ? i : 9) || d_tc[1] !== (i == 10)) begin
        errors++;
        $display("[TB] FAIL sat_up step %0d: got count=%0d tc=%b", i, d_count[1], d_tc[1]);
      end
    end
  endtask

  task automatic test_wrap_down();
    increment = 1'b0; do_count = 1'b1;
    cycle();
    checks++;
    if (d_count[0] !== 8'd9 || d_tc[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_down: got count=%0d tc=%b, want 9 1", d_count[0], d_tc[0]);
    end
    do_count = 1'b0;
    cycle();
    checks++;
    if (d_count[0] !== 8'd9 || d_tc[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_down_hold: got count=%0d tc=%b, want 9 0", d_count[0], d_tc[0]);
    end
  endtask

  task automatic test_saturate();
    load = 1'b1; load_value = 8'd9; do_count = 1'b0;
    cycle();
    load = 1'b0; do_count = 1'b1; increment = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (d_count[1] !== 8'd9 || d_tc[1] !== 1'b1 || d_max[1] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL saturate step %0d: got count=%0d tc=%b max=%b, want 9 1 1",
                 i, d_count[1], d_tc[1], d_max[1]);
      end
    end
    do_count = 1'b0;
    cycle();
    checks++;
    if (d_count[1] !== 8'd9 || d_tc[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL saturate_idle: got count=%0d tc=%b, want 9 0", d_count[1], d_tc[1]);
    end
  endtask

  task automatic test_prescaler();
    load = 1'b1; load_value = 8'd0;
    cycle();
    load = 1'b0; do_count = 1'b1; increment = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      checks++;
      if (d_count[2] !== 8'(i / 4) || d_tc[2] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL prescale cycle %0d: got count=%0d tc=%b, want %0d 0",
                 i, d_count[2], d_tc[2], i / 4);
      end
    end
    cycle();
    cycle();
    do_count = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    checks++;
    if (d_count[2] !== 8'd3) begin
      errors++;
      $display("[TB] FAIL prescale_pause: got count=%0d, want 3", d_count[2]);
    end
    do_count = 1'b1;
    cycle();
    checks++;
    if (d_count[2] !== 8'd3) begin
      errors++;
      $display("[TB] FAIL prescale_resume1: got count=%0d, want 3", d_count[2]);
    end
    cycle();
    checks++;
    if (d_count[2] !== 8'd4) begin
      errors++;
      $display("[TB] FAIL prescale_resume2: got count=%0d, want 4", d_count[2]);
    end
  endtask

  task automatic test_load_clamp();
    load = 1'b1; load_value = 8'd200; do_count = 1'b1; increment = 1'b1;
    cycle();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_count[k] !== 8'd9 || d_tc[k] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL load_clamp dut%0d: got count=%0d tc=%b, want 9 0", k, d_count[k], d_tc[k]);
      end
    end
    load = 1'b0; increment = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      checks++;
      if (d_count[2] !== 8'((i < 4) ? 9 : 8)) begin
        errors++;
        $display("[TB] FAIL load_prescale_clear cycle %0d: got count=%0d", i, d_count[2]);
      end
    end
    load = 1'b1; load_value = 8'd5; do_count = 1'b0;
    cycle();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_count[k] !== 8'd5) begin
        errors++;
        $display("[TB] FAIL load5 dut%0d: got count=%0d, want 5", k, d_count[k]);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid();
    load = 1'b1; load_value = 8'd0;
    cycle();
    load = 1'b0; do_count = 1'b1; increment = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b0; load = 1'b1; load_value = 8'd7;
    cycle();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_count[k] !== 8'd0 || d_tc[k] !== 1'b0 || d_min[k] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_mid dut%0d: got count=%0d tc=%b min=%b, want 0 0 1",
                 k, d_count[k], d_tc[k], d_min[k]);
      end
    end
    rst = 1'b1; load = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      checks++;
      if (d_count[2] !== 8'((i < 4) ? 0 : 1)) begin
        errors++;
        $display("[TB] FAIL reset_mid_restart cycle %0d: got count=%0d", i, d_count[2]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 49) != 0);
      load       = ($urandom_range(0, 9) == 0);
      load_value = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      do_count   = ($urandom_range(0, 3) != 0);
      increment  = ($urandom_range(0, 1) != 0);
      cycle();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (d_count[k] !== 8'(m_count[k]) || d_tc[k] !== m_tc[k] ||
            d_max[k] !== (m_count[k] == MODEL_MAX) || d_min[k] !== (m_count[k] == 0)) begin
          errors++;
          $display("[TB] FAIL random cyc %0d dut%0d: got count=%0d tc=%b max=%b min=%b, want count=%0d tc=%b",
                   i, k, d_count[k], d_tc[k], d_max[k], d_min[k], m_count[k], m_tc[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_prescaler();
    test_load_clamp();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prescaled_updown_counter.md
Name: prescaled_updown_counter

Overview:
- Parametrised next-generation up/down counter for the LED demo designs.
- Adds the following over the fixed 8-bit counter:
  - configurable width and upper limit (modulus);
  - wrap or saturate mode;
  - a clock-enable prescaler;
  - a parallel load;
  - terminal-count and boundary flags.
- Sits between board buttons/switches and the LED bank or a downstream display driver.

Parameters:
- WIDTH, 8: counter width in bits; legal 2..32.
- MAX_VALUE, 255: highest count value; legal 1..2^WIDTH-1. Count range is 0..MAX_VALUE.
- PRESCALE, 1: enabled cycles per count step; legal 1..65535. 1 means a step on every enabled cycle.
- SATURATE, 0: 0 means wrap at the boundaries; 1 means hold at the boundaries.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous, active-low.
- do_count, input, 1: count enable; advances the prescaler while high.
- increment, input, 1: direction; 1 is up, 0 is down. Sampled on the step cycle.
- load, input, 1: parallel load strobe.
- load_value, input, WIDTH: value loaded when load=1.
- count, output, WIDTH: current count; registered.
- tc, output, 1: terminal-count pulse; registered, high for exactly one cycle.
- at_max, output, 1: count==MAX_VALUE; combinational from the count register.
- at_min, output, 1: count==0; combinational from the count register.

Behaviour:
- Reset (rst=0 at a rising edge) gives: count=0, prescaler=0, tc=0, at_min=1, at_max=0.
- Reset has top priority and may abort any operation, including a load or a prescaler period in progress.
- Priority per edge: rst > load > step.
- Load:
  - count <= load_value, clamped: if load_value > MAX_VALUE then count <= MAX_VALUE.
  - prescaler <= 0, tc <= 0.
  - do_count is ignored in a load cycle.
- Prescaler:
  - When do_count=1 and load=0: if prescaler==PRESCALE-1, a step occurs and prescaler <= 0; otherwise prescaler <= prescaler+1.
  - When do_count=0 the prescaler holds its value; it is not cleared.
- Step, up (increment=1):
  - If count<MAX_VALUE: count <= count+1.
  - Else in wrap mode: count <= 0, tc <= 1.
  - Else in saturate mode: count holds, tc <= 1.
- Step, down (increment=0):
  - If count>0: count <= count-1.
  - Else in wrap mode: count <= MAX_VALUE, tc <= 1.
  - Else in saturate mode: count holds, tc <= 1.
- tc is 0 on every cycle without a boundary step.
- Repeated boundary steps in saturate mode give one tc pulse per step.
- Latency:
  - count and tc change on the same edge that qualifies the step; they are visible in the following cycle.
  - With PRESCALE=N and do_count held high, steps occur every N cycles; the first step is N edges after enable.
- Direction changes take effect at the next step. There is no effect on the prescaler.
- Invariant: count never exceeds MAX_VALUE.
- All arithmetic is WIDTH-bit unsigned. The prescaler counter is 16 bits.

Optional Feature:
- Macro: PRESCALED_COUNTER_INPUT_SYNC_EN.
- When defined:
  - do_count, increment and load each pass through a 2-flop synchronizer before use. This adds 2 cycles of latency on each of these inputs.
  - The synchronizer flops reset to 0 under rst.
  - load_value is not synchronized. It must be stable from 3 cycles before the load until the load takes effect.
- When undefined, the inputs are used directly with the latency given above.

Test Plan:
- Reset then wrap-up: WIDTH=8, MAX_VALUE=9, PRESCALE=1, SATURATE=0, rst=0 for 2 cycles, then do_count=1, increment=1 for 10 cycles.
  - Required: count 1..9, then 0.
  - Required: tc=1 only in the cycle count returns to 0.
  - Required: at_max=1 while count=9.
- Wrap-down: from count=0, one down step.
  - Required: count=9, tc=1 for one cycle.
- Saturate: SATURATE=1, MAX_VALUE=9, count=9, three up steps.
  - Required: count stays 9, tc pulses 3 times, at_max=1 throughout.
- Prescaler: PRESCALE=4, do_count=1 for 12 cycles.
  - Required: count 0 to 3, with steps on every 4th edge.
  - Drop do_count for 5 cycles mid-period with the prescaler at 2, then resume.
  - Required: the next step comes after 2 more enabled cycles.
- Load priority and clamp:
  - load=1, load_value=200, MAX_VALUE=9, with do_count=1 in the same cycle. Required: count=9, tc=0, prescaler cleared.
  - load_value=5. Required: count=5.
- Reset mid-operation: assert rst=0 during a count with PRESCALE=4 and the prescaler at 3, with load=1 in the same cycle.
  - Required: count=0, tc=0.
  - Required: after release, the first step occurs 4 enabled cycles later.
